// File: rtl/alu_operand_loader.sv
// Operand stage for the board ALU: debounces a load button and captures two 4-bit
// operands A then B from SW, presenting them as ALUIn = {B, A}.
module alu_operand_loader #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic       CLOCK_50,
    input  logic       Resetn,
    input  logic [3:0] SW,
    input  logic       KEY_n,
    output logic [7:0] ALUIn,
    output logic       ready,
    output logic       done,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        LOAD_A  = 2'b00,
        LOAD_B  = 2'b01,
        READY   = 2'b10,
        ILLEGAL = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;
    logic [3:0]       r_a;
    logic [3:0]       r_b;
    state_t           r_state;
    logic             r_ready;
    logic             r_done;

    // Synchroniser and debouncer; press fires on the same edge stable falls 1->0.
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_stable <= 1'b1;
            r_cnt    <= '0;
            r_press  <= 1'b0;
        end else begin
            r_sync1 <= KEY_n;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
                r_press  <= r_stable;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Operand sequencing FSM with registered ready/done.
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            r_a     <= 4'h0;
            r_b     <= 4'h0;
            r_state <= LOAD_A;
            r_ready <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                LOAD_A: begin
                    if (r_press) begin
                        r_a     <= SW;
                        r_state <= LOAD_B;
                        r_ready <= 1'b0;
                    end
                end
                LOAD_B: begin
                    if (r_press) begin
                        r_b     <= SW;
                        r_state <= READY;
                        r_ready <= 1'b1;
                        r_done  <= 1'b1;
                    end
                end
                READY: begin
                    if (r_press) begin
                        r_a     <= SW;
                        r_state <= LOAD_B;
                        r_ready <= 1'b0;
                    end
                end
                default: begin
                    r_state <= LOAD_A;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign ALUIn = {r_b, r_a};
    assign ready = r_ready;
    assign done  = r_done;
    assign state = r_state;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader with a short debounce window (4 cycles).
module tb_alu_operand_loader;

    logic       clk;
    logic       rstn;
    logic [3:0] sw;
    logic       key_n;
    logic [7:0] alu_in;
    logic       ready;
    logic       done;
    logic [1:0] state;

    int n_tests;
    int n_fail;
    int done_cnt;

    alu_operand_loader #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .CLOCK_50(clk),
        .Resetn  (rstn),
        .SW      (sw),
        .KEY_n   (key_n),
        .ALUIn   (alu_in),
        .ready   (ready),
        .done    (done),
        .state   (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press_release(input int hold);
        key_n = 1'b0;
        ticks(hold);
        key_n = 1'b1;
        ticks(20);
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        done_cnt = 0;
        rstn     = 1'b0;
        key_n    = 1'b1;
        sw       = 4'h0;

        // 1. reset and idle
        #12;
        check("rst_aluin", alu_in, 8'h00);
        check("rst_state", state, 2'b00);
        check("rst_ready", ready, 1'b0);
        check("rst_done", done, 1'b0);
        tick();
        rstn = 1'b1;
        ticks(10);
        for (int i = 0; i < 8; i++) begin
            sw = 4'(i * 3 + 1);
            tick();
        end
        check("idle_sw_aluin", alu_in, 8'h00);
        check("idle_state", state, 2'b00);

        // 2. load A=1 then B=3
        sw = 4'h1;
        press_release(20);
        check("loadA_state", state, 2'b01);
        check("loadA_aluin", alu_in, 8'h01);
        sw = 4'h3;
        press_release(20);
        check("loadB_aluin", alu_in, 8'h31);
        check("loadB_state", state, 2'b10);
        check("loadB_ready", ready, 1'b1);
        check("loadB_done_cnt", done_cnt, 1);

        // 5. reload from READY
        sw = 4'h8;
        press_release(20);
        check("reloadA_aluin", alu_in, 8'h38);
        check("reloadA_state", state, 2'b01);
        check("reloadA_ready", ready, 1'b0);
        sw = 4'h5;
        press_release(20);
        check("reloadB_aluin", alu_in, 8'h58);
        check("reloadB_done_cnt", done_cnt, 2);
        check("reloadB_state", state, 2'b10);

        // 4. glitch of 3 cycles is ignored
        sw = 4'hC;
        key_n = 1'b0;
        ticks(3);
        key_n = 1'b1;
        ticks(20);
        check("glitch_state", state, 2'b10);
        check("glitch_aluin", alu_in, 8'h58);

        // 4b. 4+ cycle press: press after edge 6, A load at edge 7
        key_n = 1'b0;
        ticks(6);
        check("lat_e6_state", state, 2'b10);
        tick();
        check("lat_e7_state", state, 2'b01);
        check("lat_e7_aluin", alu_in, 8'h5C);
        ticks(20);
        key_n = 1'b1;
        ticks(20);
        check("held_one_event", state, 2'b01);

        // 3. bounce every 2 cycles for 30 cycles, then steady low
        sw = 4'h9;
        for (int i = 0; i < 15; i++) begin
            key_n = (i % 2 == 0) ? 1'b1 : 1'b0;
            ticks(2);
        end
        check("bounce_no_press", state, 2'b01);
        key_n = 1'b0;
        ticks(6);
        check("bounce_e6_state", state, 2'b01);
        check("bounce_e6_done", done, 1'b0);
        tick();
        check("bounce_e7_state", state, 2'b10);
        check("bounce_e7_aluin", alu_in, 8'h9C);
        check("bounce_e7_done", done, 1'b1);
        check("bounce_e7_ready", ready, 1'b1);
        tick();
        check("bounce_e8_done", done, 1'b0);
        key_n = 1'b1;
        ticks(20);
        check("bounce_done_cnt", done_cnt, 3);

        // 6. async reset mid-sequence, button held across release
        sw = 4'h2;
        press_release(20);
        check("pre_rst_aluin", alu_in, 8'h92);
        key_n = 1'b0;
        #3;
        rstn = 1'b0;
        #1;
        check("async_rst_aluin", alu_in, 8'h00);
        check("async_rst_state", state, 2'b00);
        ticks(5);
        rstn = 1'b1;
        sw = 4'h7;
        ticks(6);
        check("held_rst_e6_state", state, 2'b00);
        tick();
        check("held_rst_e7_state", state, 2'b01);
        check("held_rst_e7_aluin", alu_in, 8'h07);
        ticks(30);
        check("held_rst_single", state, 2'b01);
        key_n = 1'b1;
        ticks(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
